// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   EX-stage branch resolution for LEGv8: decodes B, BL, CBZ, CBNZ, B.cond and BR,
//   holds the NZVC flag register, registers the PC-control bundle one cycle after
//   the instruction is sampled, and squashes wrong-path fetches for FLUSH_CYCLES
//   cycles after every taken branch.
//
//   Build option: define FLAG_FORWARD_EN to let a B.cond use aluFlags when setFlags
//   is asserted in the same cycle. Without it B.cond always reads the flag register.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RUN    | accepting instructions; flush low
//   SQUASH | flush high; valid instructions dropped; cnt_q cycles remain after this one

module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] instr,
  input  logic [63:0] regData,
  input  logic        setFlags,
  input  logic [3:0]  aluFlags,
  output logic [18:0] condAddr19,
  output logic [25:0] brAddr26,
  output logic        uncondBr,
  output logic        brTaken,
  output logic        branchReg,
  output logic [63:0] Rd,
  output logic        linkWrite,
  output logic        flush
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic [18:0] cond_addr_q, cond_addr_d;
  logic [25:0] br_addr_q, br_addr_d;
  logic        uncond_q, uncond_d;
  logic        taken_q, taken_d;
  logic        breg_q, breg_d;
  logic        link_q, link_d;
  logic [63:0] rd_q, rd_d;

  logic        is_b, is_bl, is_cbz, is_cbnz, is_bcond, is_br;
  logic        accept;
  logic [3:0]  flags_use;

  // Condition codes pair up: odd encodings invert the even one, except 1111 (always).
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    {n, z, cf, v} = f;
    unique case (c[3:1])
      3'b000:  r = z;
      3'b001:  r = cf;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = cf & ~z;
      3'b101:  r = (n == v);
      3'b110:  r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c != 4'hF)) r = ~r;
    return r;
  endfunction

  // Opcode decode and the flag source a B.cond will test this cycle.
  always_comb begin
    is_b     = (instr[31:26] == 6'b000101);
    is_bl    = (instr[31:26] == 6'b100101);
    is_cbz   = (instr[31:24] == 8'b10110100);
    is_cbnz  = (instr[31:24] == 8'b10110101);
    is_bcond = (instr[31:24] == 8'b01010100);
    is_br    = (instr[31:21] == 11'b11010110000);
`ifdef FLAG_FORWARD_EN
    flags_use = setFlags ? aluFlags : flags_q;
`else
    flags_use = flags_q;
`endif
  end

  // Branch decision and next-state logic; strobes default low so drops emit nothing.
  always_comb begin
    accept      = valid && (state_q == RUN);
    cond_addr_d = instr[23:5];
    br_addr_d   = instr[25:0];
    uncond_d    = 1'b0;
    taken_d     = 1'b0;
    breg_d      = 1'b0;
    link_d      = 1'b0;
    rd_d        = rd_q;
    flags_d     = setFlags ? aluFlags : flags_q;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (accept) begin
      if (is_b) begin
        uncond_d = 1'b1;
        taken_d  = 1'b1;
      end else if (is_bl) begin
        uncond_d = 1'b1;
        taken_d  = 1'b1;
        link_d   = 1'b1;
      end else if (is_cbz) begin
        taken_d  = (regData == 64'd0);
      end else if (is_cbnz) begin
        taken_d  = (regData != 64'd0);
      end else if (is_bcond) begin
        taken_d  = cond_holds(instr[3:0], flags_use);
      end else if (is_br) begin
        uncond_d = 1'b1;
        taken_d  = 1'b1;
        breg_d   = 1'b1;
        rd_d     = regData;
      end
    end

    unique case (state_q)
      RUN: begin
        if (taken_d) begin
          state_d = SQUASH;
          cnt_d   = CNT_INIT;
        end
      end
      SQUASH: begin
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // State, flag register and the registered PC-control bundle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      flags_q     <= 4'd0;
      cond_addr_q <= '0;
      br_addr_q   <= '0;
      uncond_q    <= 1'b0;
      taken_q     <= 1'b0;
      breg_q      <= 1'b0;
      link_q      <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      cond_addr_q <= cond_addr_d;
      br_addr_q   <= br_addr_d;
      uncond_q    <= uncond_d;
      taken_q     <= taken_d;
      breg_q      <= breg_d;
      link_q      <= link_d;
      rd_q        <= rd_d;
    end
  end

  assign condAddr19 = cond_addr_q;
  assign brAddr26   = br_addr_q;
  assign uncondBr   = uncond_q;
  assign brTaken    = taken_q;
  assign branchReg  = breg_q;
  assign Rd         = rd_q;
  assign linkWrite  = link_q;
  // flush follows the state register so it lines up with brTaken and drops with reset.
  assign flush      = (state_q == SQUASH);

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int FC = 2;
  localparam logic [31:0] NOP = 32'h8B020020;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] instr = NOP;
  logic [63:0] regData = '0;
  logic        setFlags = 1'b0;
  logic [3:0]  aluFlags = '0;
  logic [18:0] condAddr19;
  logic [25:0] brAddr26;
  logic        uncondBr, brTaken, branchReg, linkWrite, flush;
  logic [63:0] Rd;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          squash_left;
  logic [3:0]  flags_m;
  logic [18:0] e_cond;
  logic [25:0] e_br;
  logic        e_unc, e_tk, e_breg, e_link, e_flush;
  logic [63:0] e_rd;

  branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .valid(valid), .instr(instr), .regData(regData),
    .setFlags(setFlags), .aluFlags(aluFlags), .condAddr19(condAddr19),
    .brAddr26(brAddr26), .uncondBr(uncondBr), .brTaken(brTaken),
    .branchReg(branchReg), .Rd(Rd), .linkWrite(linkWrite), .flush(flush)
  );

  always #5 clock = ~clock;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cc;
      4'd3:  return !cc;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cc && !z;
      4'd9:  return !(cc && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    squash_left = 0; flags_m = 4'd0;
    e_cond = '0; e_br = '0; e_unc = 0; e_tk = 0; e_breg = 0; e_link = 0; e_flush = 0; e_rd = '0;
  endtask

  // Drive one cycle (called at a negedge), update the model, return at the next negedge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] rd,
                       input logic sf, input logic [3:0] af);
    logic acc;
    logic [3:0] fsel;
    valid = v; instr = ins; regData = rd; setFlags = sf; aluFlags = af;
`ifdef FLAG_FORWARD_EN
    fsel = sf ? af : flags_m;
`else
    fsel = flags_m;
`endif
    acc = v && (squash_left == 0);
    e_cond = ins[23:5]; e_br = ins[25:0];
    e_unc = 0; e_tk = 0; e_breg = 0; e_link = 0;
    if (acc) begin
      if (ins[31:26] == 6'b000101) begin e_unc = 1; e_tk = 1; end
      else if (ins[31:26] == 6'b100101) begin e_unc = 1; e_tk = 1; e_link = 1; end
      else if (ins[31:24] == 8'hB4) e_tk = (rd == 64'd0);
      else if (ins[31:24] == 8'hB5) e_tk = (rd != 64'd0);
      else if (ins[31:24] == 8'h54) e_tk = cond_ok(ins[3:0], fsel);
      else if (ins[31:21] == 11'b11010110000) begin e_unc = 1; e_tk = 1; e_breg = 1; e_rd = rd; end
    end
    if (squash_left > 0) squash_left = squash_left - 1;
    else if (e_tk) squash_left = FC;
    e_flush = (squash_left > 0);
    if (sf) flags_m = af;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, NOP, 64'd0, 0, 4'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    n_tests++;
    if ({condAddr19, brAddr26, uncondBr, brTaken, branchReg, Rd, linkWrite, flush} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0",
        {condAddr19, brAddr26, uncondBr, brTaken, branchReg, Rd, linkWrite, flush});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_b_squash();
    drive(1, 32'h14000002, 64'd0, 0, 4'd0);
    n_tests++;
    if ({brTaken, uncondBr, flush} !== 3'b111 || brAddr26 !== 26'd2) begin
      n_fail++; $display("FAIL t1_b got tk/unc/fl=%b br=%h exp 111 br=2", {brTaken, uncondBr, flush}, brAddr26);
    end
    drive(1, 32'h14000005, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b0 || flush !== 1'b1) begin
      n_fail++; $display("FAIL t1_drop1 got tk=%b fl=%b exp tk=0 fl=1", brTaken, flush);
    end
    drive(1, 32'h14000007, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL t1_drop2 got tk=%b fl=%b exp tk=0 fl=0", brTaken, flush);
    end
  endtask

  task automatic test_cbz();
    drive(1, 32'hB40003C1, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1 || uncondBr !== 1'b0 || condAddr19 !== 19'd30) begin
      n_fail++; $display("FAIL t2_cbz_taken got tk=%b unc=%b ca=%h exp 1 0 1e", brTaken, uncondBr, condAddr19);
    end
    idle(FC);
    drive(1, 32'hB40003C1, 64'd5, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL t2_cbz_not got tk=%b fl=%b exp 0 0", brTaken, flush);
    end
  endtask

  task automatic test_bcond();
    drive(0, NOP, 64'd0, 1, 4'b1000);
    drive(1, 32'h54FFFFEB, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1 || condAddr19 !== 19'h7FFFF || flush !== 1'b1) begin
      n_fail++; $display("FAIL t3_lt_taken got tk=%b ca=%h fl=%b exp 1 7ffff 1", brTaken, condAddr19, flush);
    end
    idle(FC);
    drive(0, NOP, 64'd0, 1, 4'b1001);
    drive(1, 32'h54FFFFEB, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL t3_lt_not got tk=%b fl=%b exp 0 0", brTaken, flush);
    end
  endtask

  task automatic test_forward();
    logic exp_tk;
`ifdef FLAG_FORWARD_EN
    exp_tk = 1'b1;
`else
    exp_tk = 1'b0;
`endif
    drive(1, 32'h54000040, 64'd0, 1, 4'b0100);
    n_tests++;
    if (brTaken !== exp_tk || condAddr19 !== 19'd2) begin
      n_fail++; $display("FAIL t4_fwd got tk=%b ca=%h exp tk=%b ca=2", brTaken, condAddr19, exp_tk);
    end
    idle(FC);
    drive(1, 32'h54000040, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1) begin
      n_fail++; $display("FAIL t4_regz got tk=%b exp 1", brTaken);
    end
    idle(FC);
  endtask

  task automatic test_br_bl();
    drive(1, 32'hD61F03C0, 64'd69, 0, 4'd0);
    n_tests++;
    if ({branchReg, brTaken, uncondBr, linkWrite} !== 4'b1110 || Rd !== 64'd69) begin
      n_fail++; $display("FAIL t5_br got brg/tk/unc/lk=%b rd=%0d exp 1110 rd=69",
        {branchReg, brTaken, uncondBr, linkWrite}, Rd);
    end
    idle(FC);
    drive(1, 32'h97FFFFFB, 64'd7, 0, 4'd0);
    n_tests++;
    if ({linkWrite, brTaken, uncondBr, branchReg} !== 4'b1110 || brAddr26 !== 26'h3FFFFFB || Rd !== 64'd69) begin
      n_fail++; $display("FAIL t5_bl got lk/tk/unc/brg=%b ba=%h rd=%0d exp 1110 3fffffb 69",
        {linkWrite, brTaken, uncondBr, branchReg}, brAddr26, Rd);
    end
    idle(FC);
  endtask

  task automatic test_reset_mid_squash();
    drive(1, 32'h14000002, 64'd0, 0, 4'd0);
    reset = 1'b1;
    #1;
    n_tests++;
    if (flush !== 1'b0 || brTaken !== 1'b0 || brAddr26 !== 26'd0 || uncondBr !== 1'b0) begin
      n_fail++; $display("FAIL t6_async got fl=%b tk=%b ba=%h unc=%b exp all 0", flush, brTaken, brAddr26, uncondBr);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(1, 32'h14000002, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1 || flush !== 1'b1 || brAddr26 !== 26'd2) begin
      n_fail++; $display("FAIL t6_after got tk=%b fl=%b ba=%h exp 1 1 2", brTaken, flush, brAddr26);
    end
    idle(FC);
  endtask

  task automatic test_back_to_back();
    int fl_cnt;
    drive(1, 32'hB5000020, 64'd0, 0, 4'd0);
    drive(1, 32'hB5000040, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b0 || flush !== 1'b0 || condAddr19 !== 19'd2) begin
      n_fail++; $display("FAIL b2b_cbnz got tk=%b fl=%b ca=%h exp 0 0 2", brTaken, flush, condAddr19);
    end
    drive(1, 32'h5400006E, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL b2b_al got tk=%b fl=%b exp 1 1", brTaken, flush);
    end
    for (int i = 0; i < FC; i++) drive(1, 32'h14000009, 64'd0, 0, 4'd0);
    drive(1, 32'h14000003, 64'd0, 0, 4'd0);
    n_tests++;
    if (brTaken !== 1'b1 || brAddr26 !== 26'd3) begin
      n_fail++; $display("FAIL b2b_first_after got tk=%b ba=%h exp 1 3", brTaken, brAddr26);
    end
    fl_cnt = 0;
    for (int i = 0; i < FC + 3; i++) begin
      if (flush === 1'b1) fl_cnt++;
      drive(0, NOP, 64'd0, 0, 4'd0);
    end
    n_tests++;
    if (fl_cnt != FC) begin
      n_fail++; $display("FAIL flush_width got %0d exp %0d", fl_cnt, FC);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [63:0] rd;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ($urandom_range(0, 6))
        0: ins = {6'b000101, 26'($urandom)};
        1: ins = {6'b100101, 26'($urandom)};
        2: ins = {8'hB4, 24'($urandom)};
        3: ins = {8'hB5, 24'($urandom)};
        4, 5: ins = {8'h54, 24'($urandom)};
        default: ins = ($urandom_range(0, 1) == 0) ? {11'b11010110000, 21'($urandom)} : (NOP ^ 32'($urandom_range(0, 255)));
      endcase
      rd = ($urandom_range(0, 1) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      drive($urandom_range(0, 9) < 8, ins, rd, $urandom_range(0, 2) == 0, 4'($urandom));
      n_tests++;
      if (brTaken !== e_tk || uncondBr !== e_unc || branchReg !== e_breg || linkWrite !== e_link || flush !== e_flush) begin
        n_fail++; $display("FAIL rnd_strobes cyc %0d got tk/unc/brg/lk/fl=%b exp %b", cyc,
          {brTaken, uncondBr, branchReg, linkWrite, flush}, {e_tk, e_unc, e_breg, e_link, e_flush});
      end
      n_tests++;
      if (condAddr19 !== e_cond || brAddr26 !== e_br || Rd !== e_rd) begin
        n_fail++; $display("FAIL rnd_data cyc %0d got ca=%h ba=%h rd=%h exp ca=%h ba=%h rd=%h", cyc,
          condAddr19, brAddr26, Rd, e_cond, e_br, e_rd);
      end
    end
    idle(FC);
  endtask

  initial begin
    test_reset();
    test_b_squash();
    test_cbz();
    idle(FC);
    test_bcond();
    idle(FC);
    test_forward();
    test_br_bl();
    test_reset_mid_squash();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
